// File: rtl/fact_mul_acc.sv
// Purpose: running-product accumulator for the factorial datapath. It multiplies each accepted operand into the
//          current result with an iterative shift-add multiplier, one multiplier bit per cycle.
// Latency: result updates OPW cycles after the accept edge. Throughput is one operand every OPW+1 cycles.
// Backpressure: op_ready is low while a multiply is in flight, during clr, and during reset. Upstream holds its operand until accepted.
// Ports: clk/rst (synchronous, active-low); clr restarts the product; op_valid/op_data/op_last/op_ready form the
//        operand handshake; busy, result, res_valid and ovf report the product state.
module fact_mul_acc #(
    parameter int OPW  = 9,
    parameter int ACCW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            op_valid,
    input  logic [OPW-1:0]  op_data,
    input  logic            op_last,
    output logic            op_ready,
    output logic            busy,
    output logic [ACCW-1:0] result,
    output logic            res_valid,
    output logic            ovf
);

    localparam int PW = ACCW + OPW;
    localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(OPW - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state;
    logic [PW-1:0]  mcand;      // multiplicand, shifted left once per MUL cycle
    logic [OPW-1:0] mplier;     // multiplier, shifted right so bit 0 is always the current bit
    logic [PW-1:0]  partial;
    logic [PW-1:0]  partial_nxt;
    logic [CW-1:0]  bit_cnt;
    logic           last_q;

    assign op_ready = (state == IDLE) && !clr && rst;
    assign busy     = (state == MUL);

    // Shifting mcand each cycle is equivalent to adding (multiplicand << bit index).
    assign partial_nxt = partial + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            result    <= ACCW'(1);
            res_valid <= 1'b0;
            ovf       <= 1'b0;
            bit_cnt   <= '0;
            last_q    <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            partial   <= '0;
        end else if (clr) begin
            // Any in-flight multiply is dropped, and the product restarts at 1.
            state     <= IDLE;
            result    <= ACCW'(1);
            ovf       <= 1'b0;
            res_valid <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // op_ready is implied here: the state is IDLE, clr is low and rst is high.
                    if (op_valid) begin
                        mcand     <= PW'(result);
                        // 0! = 1, so a zero factor must leave the product unchanged.
                        mplier    <= (op_data == '0) ? OPW'(1) : op_data;
                        last_q    <= op_last;
                        partial   <= '0;
                        bit_cnt   <= '0;
                        res_valid <= 1'b0;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    partial <= partial_nxt;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        result    <= partial_nxt[ACCW-1:0];
                        ovf       <= ovf | (|partial_nxt[PW-1:ACCW]);
                        res_valid <= last_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_mul_acc.sv
module tb_fact_mul_acc;

    localparam int OPW  = 9;
    localparam int ACCW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic            op_valid;
    logic [OPW-1:0]  op_data;
    logic            op_last;
    logic            op_ready;
    logic            busy;
    logic [ACCW-1:0] result;
    logic            res_valid;
    logic            ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int seq_q[$];

    // Reference model: the true product reduced modulo 2^ACCW, plus a sticky overflow flag.
    longint unsigned m_res;
    bit              m_ovf;

    fact_mul_acc #(.OPW(OPW), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .op_valid(op_valid), .op_data(op_data), .op_last(op_last),
        .op_ready(op_ready), .busy(busy), .result(result),
        .res_valid(res_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_res = 1;
        m_ovf = 1'b0;
    endtask

    task automatic model_mul(input int v);
        longint unsigned p;
        p = m_res * longint'((v == 0) ? 1 : v);
        m_res = p & 64'hFFFF_FFFF;
        if ((p >> ACCW) != 0) m_ovf = 1'b1;
    endtask

    // Presents one operand and waits until it is accepted. It returns at the negedge after the accept edge.
    // e0 is the value cyc takes at the accept edge.
    task automatic accept_one(input int v, input bit last, output int e0);
        int waitc;
        op_valid = 1'b1;
        op_data  = OPW'(v);
        op_last  = last;
        #1;
        waitc = 0;
        while (!op_ready && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        if (!op_ready) begin
            chk("accept_timeout", 0, 1);
            e0 = -1;
            return;
        end
        e0 = cyc + 1;
        chk("result_before_accept", result, m_res);
        chk("ovf_before_accept", ovf, m_ovf);
        model_mul(v);
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
        chk("res_valid_cleared", res_valid, 0);
        chk("ready_low_busy", op_ready, 0);
    endtask

    task automatic wait_done(input bit check_timing, input int e0);
        int waitc;
        op_valid = 1'b0;
        op_last  = 1'b0;
        waitc = 0;
        while (!res_valid && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        chk("res_valid_seen", res_valid, 1);
        if (check_timing) chk("res_latency", cyc - e0, OPW);
        chk("final_result", result, m_res);
        chk("final_ovf", ovf, m_ovf);
        chk("final_busy", busy, 0);
    endtask

    task automatic run_seq(input bit check_timing, input bit gaps);
        int e0;
        int prev_e0;
        prev_e0 = -1;
        e0 = -1;
        for (int i = 0; i < seq_q.size(); i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                op_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            accept_one(seq_q[i], (i == seq_q.size() - 1), e0);
            if (e0 < 0) return;
            if (check_timing && prev_e0 >= 0) chk("accept_spacing", e0 - prev_e0, OPW + 1);
            prev_e0 = e0;
        end
        wait_done(check_timing, e0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int clr_cyc;
        int len;

        rst = 1'b0; clr = 1'b0; op_valid = 1'b0; op_data = '0; op_last = 1'b0;
        model_clear();

        // Reset
        @(negedge clk);
        chk("ready_in_reset", op_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_result", result, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_ready", op_ready, 1);
        @(negedge clk);

        // 5! with op_valid held continuously, including timing checks
        do_clr();
        seq_q = '{5, 4, 3, 2, 1};
        run_seq(1'b1, 1'b0);
        chk("fact5", result, 120);
        chk("fact5_ovf", ovf, 0);

        // 12!
        do_clr();
        seq_q = '{12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
        run_seq(1'b1, 1'b0);
        chk("fact12", result, 479001600);
        chk("fact12_ovf", ovf, 0);

        // 13! overflows ACCW
        do_clr();
        seq_q = '{13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
        run_seq(1'b1, 1'b0);
        chk("fact13", result, 1932053504);
        chk("fact13_ovf", ovf, 1);

        // Single zero operand with last
        do_clr();
        seq_q = '{0};
        run_seq(1'b1, 1'b0);
        chk("zero_single", result, 1);
        chk("zero_single_rv", res_valid, 1);

        // clr in the 4th MUL cycle of operand 7, with the next operand already valid
        do_clr();
        seq_q = '{3};
        run_seq(1'b0, 1'b0);
        accept_one(7, 1'b0, e0);
        repeat (3) @(negedge clk);
        clr = 1'b1; op_valid = 1'b1; op_data = OPW'(6); op_last = 1'b1;
        #1;
        chk("clr_ready_low", op_ready, 0);
        chk("clr_busy_before", busy, 1);
        clr_cyc = cyc + 1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        #1;
        chk("clr_busy", busy, 0);
        chk("clr_result", result, 1);
        chk("clr_res_valid", res_valid, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_ready_after", op_ready, 1);
        accept_one(6, 1'b1, e0);
        chk("clr_accept_edge", e0, clr_cyc + 1);
        wait_done(1'b1, e0);
        chk("clr_then_6", result, 6);

        // Reset mid-multiply while ovf is set
        do_clr();
        seq_q = '{13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
        run_seq(1'b0, 1'b1);
        chk("pre_rst_ovf", ovf, 1);
        accept_one(5, 1'b0, e0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", op_ready, 0);
        @(negedge clk);
        chk("rst_mid_result", result, 1);
        chk("rst_mid_rv", res_valid, 0);
        chk("rst_mid_ovf", ovf, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_mid_ready_after", op_ready, 1);
        seq_q = '{3, 2, 1};
        run_seq(1'b1, 1'b0);
        chk("rst_then_6", result, 6);

        // Randomized sequences with idle gaps, checked against the model
        for (int t = 0; t < 8; t++) begin
            do_clr();
            seq_q.delete();
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++)
                seq_q.push_back(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 511)));
            run_seq(1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
